// File: rtl/matvec_engine_if.sv
// Avalon-MM pipelined read bus between matvec_engine (master) and its memory (slave).
interface matvec_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic [WORD_WIDTH-1:0] mem_readdata;
    logic                  mem_readdatavalid;
    logic                  mem_waitrequest;

    modport master (
        output mem_address, mem_read,
        input  mem_readdata, mem_readdatavalid, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read,
        output mem_readdata, mem_readdatavalid, mem_waitrequest
    );
endinterface

// File: rtl/matvec_engine.sv
// Matrix-vector multiply: fetches B then ROWS rows of A over a pipelined
// read master, then runs ROWS parallel MAC lanes, one column per cycle.
module matvec_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 32,
    parameter int SIGNED     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ROWS*ACC_WIDTH-1:0] c_out,
    matvec_engine_if.master           mem
);
    localparam int WORD_WIDTH = COLS * DATA_WIDTH;
    localparam int REQ_W      = $clog2(ROWS + 2);
    localparam int RSP_W      = $clog2(ROWS + 1);
    localparam int COL_W      = $clog2(COLS + 1);

    typedef enum logic [1:0] {IDLE, FILL, CALC, DONE} state_t;

    state_t                  state, state_next;
    logic [REQ_W-1:0]        req_cnt;
    logic [RSP_W-1:0]        rsp_cnt;
    logic [COL_W-1:0]        col_cnt;
    logic [WORD_WIDTH-1:0]   b_buf;
    logic [WORD_WIDTH-1:0]   a_buf [ROWS];
    logic [ACC_WIDTH-1:0]    acc   [ROWS];
    logic [DATA_WIDTH-1:0]   a_col [ROWS];
    logic [DATA_WIDTH-1:0]   b_col;
    logic [ACC_WIDTH-1:0]    prod  [ROWS];

    logic start_ok, accept, last_rsp, last_col;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept   = mem.mem_read && !mem.mem_waitrequest;
    assign last_rsp = (state == FILL) && mem.mem_readdatavalid && (rsp_cnt == RSP_W'(ROWS));
    assign last_col = (col_cnt == COL_W'(COLS - 1));

    // Extend an element to accumulator width according to SIGNED.
    function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        if (SIGNED != 0)
            return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
        return {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = FILL;
            FILL: begin
                busy = 1'b1;
                if (last_rsp) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_col) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request issue: address advances only on acceptance, read drops after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_address <= '0;
            mem.mem_read    <= 1'b0;
            req_cnt         <= '0;
        end else if (start_ok) begin
            mem.mem_address <= base_addr;
            mem.mem_read    <= 1'b1;
            req_cnt         <= '0;
        end else if (accept) begin
            req_cnt <= req_cnt + REQ_W'(1);
            if (req_cnt == REQ_W'(ROWS))
                mem.mem_read <= 1'b0;
            else
                mem.mem_address <= mem.mem_address + ADDR_WIDTH'(1);
        end
    end

    // Column select for the current MAC step and the per-lane products.
    always_comb begin
        b_col = '0;
        for (int r = 0; r < ROWS; r++) a_col[r] = '0;
        for (int j = 0; j < COLS; j++) begin
            if (col_cnt == COL_W'(j)) begin
                b_col = b_buf[j*DATA_WIDTH +: DATA_WIDTH];
                for (int r = 0; r < ROWS; r++) a_col[r] = a_buf[r][j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int r = 0; r < ROWS; r++) prod[r] = ext(a_col[r]) * ext(b_col);
    end

    // Response capture, sticky error flag, and accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: buffers are reset because reset must leave no stale operands behind.
            rsp_cnt <= '0;
            col_cnt <= '0;
            err     <= 1'b0;
            b_buf   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                a_buf[r] <= '0;
                acc[r]   <= '0;
            end
        end else begin
            if (start_ok) begin
                rsp_cnt <= '0;
                col_cnt <= '0;
                err     <= 1'b0;
                for (int r = 0; r < ROWS; r++) acc[r] <= '0;
            end
            if (mem.mem_readdatavalid) begin
                if (state == FILL) begin
                    if (rsp_cnt == '0) b_buf <= mem.mem_readdata;
                    for (int r = 0; r < ROWS; r++)
                        if (rsp_cnt == RSP_W'(r + 1)) a_buf[r] <= mem.mem_readdata;
                    rsp_cnt <= rsp_cnt + RSP_W'(1);
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == CALC) begin
                for (int r = 0; r < ROWS; r++) acc[r] <= acc[r] + prod[r];
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

    // Results are the accumulators; they are final and held once DONE is reached.
    always_comb begin
        c_out = '0;
        for (int r = 0; r < ROWS; r++) c_out[r*ACC_WIDTH +: ACC_WIDTH] = acc[r];
    end
endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench: an unsigned and a signed engine share one memory
// responder; expected results go into per-instance queues checked on done.
`timescale 1ns/1ps
module tb_matvec_engine;
    localparam int DW        = 8;
    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int ACC       = 24;
    localparam int AW        = 32;
    localparam int WORD      = COLS * DW;
    localparam int OUT       = ROWS * ACC;
    localparam int MEM_DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic            busy_u, done_u, err_u, busy_s, done_s, err_s;
    logic [OUT-1:0]  c_out_u, c_out_s;
    logic            wr = 1'b0;
    logic            rdv = 1'b0;
    logic [WORD-1:0] rdata = '0;

    matvec_engine_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WORD)) bus_u ();
    matvec_engine_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WORD)) bus_s ();

    assign bus_u.mem_waitrequest   = wr;
    assign bus_u.mem_readdatavalid = rdv;
    assign bus_u.mem_readdata      = rdata;
    assign bus_s.mem_waitrequest   = wr;
    assign bus_s.mem_readdatavalid = rdv;
    assign bus_s.mem_readdata      = rdata;

    matvec_engine #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(ACC),
                    .ADDR_WIDTH(AW), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy_u), .done(done_u), .err(err_u), .c_out(c_out_u), .mem(bus_u));

    matvec_engine #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(ACC),
                    .ADDR_WIDTH(AW), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy_s), .done(done_s), .err(err_s), .c_out(c_out_s), .mem(bus_s));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [OUT-1:0] act, input logic [OUT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred where none was expected", name);
    endtask

    // ---------------- memory and reference model ----------------
    logic [WORD-1:0] mem [MEM_DEPTH];

    function automatic logic [WORD-1:0] rand_word();
        logic [WORD-1:0] w;
        for (int j = 0; j < COLS; j++) w[j*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    // Plain arithmetic: c[r] = sum_k A[r][k]*B[k], reduced modulo 2^ACC.
    function automatic logic [OUT-1:0] model(input logic [AW-1:0] base, input bit sgn);
        logic [OUT-1:0]  res;
        logic [WORD-1:0] bw, arow;
        logic [AW-1:0]   ad;
        longint          sum;
        int              a, b;
        res = '0;
        bw  = mem[base[5:0]];
        for (int r = 0; r < ROWS; r++) begin
            ad   = base + AW'(1 + r);
            arow = mem[ad[5:0]];
            sum  = 0;
            for (int k = 0; k < COLS; k++) begin
                a = int'(arow[k*DW +: DW]);
                b = int'(bw[k*DW +: DW]);
                if (sgn) begin
                    if (a >= (1 << (DW - 1))) a -= (1 << DW);
                    if (b >= (1 << (DW - 1))) b -= (1 << DW);
                end
                sum += longint'(a * b);
            end
            res[r*ACC +: ACC] = sum[ACC-1:0];
        end
        return res;
    endfunction

    // ---------------- memory responder ----------------
    int            lat        = 2;
    bit            stall_en   = 1'b0;
    int            stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    bit            inject     = 1'b0;
    int            acc_cnt    = 0;
    logic [AW-1:0] pend_addr [$];
    int            pend_due  [$];

    initial begin : responder
        bit            prev_wr;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] pa;
        prev_wr   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                wr      = 1'b0;
                rdv     = 1'b0;
                prev_wr = 1'b0;
            end else begin
                if (prev_wr) begin
                    check("stall_hold_read", bus_u.mem_read, 1);
                    check("stall_hold_addr", bus_u.mem_address, prev_addr);
                end
                wr = stall_en && stall_left > 0 && bus_u.mem_read && bus_u.mem_address == stall_addr;
                if (wr) stall_left--;
                prev_wr   = wr;
                prev_addr = bus_u.mem_address;
                if (bus_u.mem_read && !wr) begin
                    pend_addr.push_back(bus_u.mem_address);
                    pend_due.push_back(cyc + lat);
                    acc_cnt++;
                end
                if (inject) begin
                    rdv    = 1'b1;
                    rdata  = '1;
                    inject = 1'b0;
                end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                    pa    = pend_addr.pop_front();
                    void'(pend_due.pop_front());
                    rdv   = 1'b1;
                    rdata = mem[pa[5:0]];
                end else begin
                    rdv   = 1'b0;
                    rdata = '0;
                end
            end
        end
    end

    // ---------------- scoreboard monitors ----------------
    logic [OUT-1:0] exp_u [$];
    logic [OUT-1:0] exp_s [$];

    initial begin : mon_u
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_u && !prev) begin
                if (exp_u.size() == 0) note_fail("done_u_unexpected");
                else check("c_out_unsigned", c_out_u, exp_u.pop_front());
            end
            prev = done_u;
        end
    end

    initial begin : mon_s
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_s && !prev) begin
                if (exp_s.size() == 0) note_fail("done_s_unexpected");
                else check("c_out_signed", c_out_s, exp_s.pop_front());
            end
            prev = done_s;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_u, 0);
        check({tag, "_done"}, done_u, 0);
        check({tag, "_err"}, err_u, 0);
        check({tag, "_c_out_u"}, c_out_u, 0);
        check({tag, "_c_out_s"}, c_out_s, 0);
        check({tag, "_mem_read"}, bus_u.mem_read, 0);
        check({tag, "_mem_address"}, bus_u.mem_address, 0);
    endtask

    // One job: start at cycle T, optional stall, optional ignored starts,
    // optional reset at column abort_k (abort_k < 0 means run to completion).
    task automatic run(input logic [AW-1:0] base, input int latency, input bit stall,
                       input bit pulses, input int abort_k);
        int t0, exp_lat, stall_cyc, n;
        @(negedge clk);
        lat        = latency;
        stall_en   = stall;
        stall_left = stall ? 3 : 0;
        stall_addr = base + AW'(2);
        acc_cnt    = 0;
        stall_cyc  = stall ? 3 : 0;
        start      = 1'b1;
        base_addr  = base;
        t0         = cyc;
        if (abort_k < 0) begin
            exp_u.push_back(model(base, 1'b0));
            exp_s.push_back(model(base, 1'b1));
        end
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom_range(0, 60));
        check("t1_busy", busy_u, 1);
        check("t1_done", done_u, 0);
        check("t1_err_cleared", err_u, 0);
        check("t1_mem_read", bus_u.mem_read, 1);
        check("t1_addr_u", bus_u.mem_address, base);
        check("t1_addr_s", bus_s.mem_address, base);
        exp_lat = ROWS + 1 + latency + COLS + 1 + stall_cyc;
        n = 0;
        while (!done_u && n < 300) begin
            if (pulses && (cyc == t0 + 3 || cyc == t0 + ROWS + 1 + latency + stall_cyc + 3)) begin
                start     = 1'b1;
                base_addr = base + AW'(5);
            end else begin
                start = 1'b0;
            end
            if (abort_k >= 0 && cyc == t0 + ROWS + 1 + latency + stall_cyc + 1 + abort_k) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                check("abort_busy_s", busy_s, 0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("abort_idle_busy", busy_u, 0);
                check("abort_idle_read", bus_u.mem_read, 0);
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done_u) begin
            note_fail("done_timeout");
            exp_u.delete();
            exp_s.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            check("done_latency", 32'(cyc - t0), 32'(exp_lat));
            check("acceptances", 32'(acc_cnt), 32'(ROWS + 1));
            check("done_signed_inst", done_s, 1);
            check("busy_in_done", busy_u, 0);
        end
    endtask

    initial begin : main
        logic [OUT-1:0] saved;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = rand_word();

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Identity matrix, B = 1..COLS.
        for (int j = 0; j < COLS; j++) mem[0][j*DW +: DW] = DW'(j + 1);
        for (int r = 0; r < ROWS; r++) begin
            mem[1 + r] = '0;
            mem[1 + r][r*DW +: DW] = DW'(1);
        end
        run(0, 2, 1'b0, 1'b0, -1);
        for (int r = 0; r < ROWS; r++) begin
            saved = '0;
            saved[ACC-1:0] = ACC'(r + 1);
            check("identity_row", OUT'(c_out_u[r*ACC +: ACC]), saved);
        end

        // Same job with a 3-cycle stall on base+2.
        run(0, 2, 1'b1, 1'b0, -1);

        // Signedness: A all 0xFF, B all 0x02.
        for (int j = 0; j < COLS; j++) mem[20][j*DW +: DW] = 8'h02;
        for (int r = 0; r < ROWS; r++) mem[21 + r] = '1;
        run(20, 2, 1'b0, 1'b0, -1);
        for (int r = 0; r < ROWS; r++) begin
            check("unsigned_ff_x_02", OUT'(c_out_u[r*ACC +: ACC]), OUT'(24'h000FF0));
            check("signed_ff_x_02", OUT'(c_out_s[r*ACC +: ACC]), OUT'(24'hFFFFF0));
        end

        // Starts during FILL and CALC must be ignored.
        run(AW'($urandom_range(30, 54)), 2, 1'b0, 1'b1, -1);

        // Stray response while in DONE.
        saved  = c_out_u;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_err_u", err_u, 1);
        check("stray_err_s", err_s, 1);
        check("stray_c_out_kept", c_out_u, saved);
        check("stray_done_kept", done_u, 1);

        // Restart from DONE with a new base and fresh data.
        for (int i = 16; i < 25; i++) mem[i] = rand_word();
        run(16, 2, 1'b0, 1'b0, -1);

        // Reset in the middle of CALC, then a clean job.
        run(30, 2, 1'b0, 1'b0, 3);
        run(30, 2, 1'b0, 1'b0, -1);

        // Randomized jobs.
        for (int t = 0; t < 8; t++) begin
            logic [AW-1:0] b;
            b = AW'($urandom_range(0, MEM_DEPTH - ROWS - 2));
            for (int i = 0; i < ROWS + 1; i++) mem[b + AW'(i)] = rand_word();
            run(b, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained_u", 32'(exp_u.size()), 0);
        check("scoreboard_drained_s", 32'(exp_s.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised matrix-vector multiply engine: `ROWS x COLS` matrix A times `COLS`-element vector B, producing `ROWS` accumulated results. It fetches B and the rows of A over a pipelined Avalon-MM read master, buffers them internally, and runs all row MACs in parallel, one column per cycle. It sits between the memory wrapper and result consumers (LED/display or host logic), and is controlled by a start/busy/done handshake.

## Interface
- `DATA_WIDTH`, 8, element width of A and B
- `ROWS`, 8, matrix rows = number of MAC lanes (1..16)
- `COLS`, 8, matrix columns = vector length (1..16); memory word = `COLS*DATA_WIDTH` bits
- `ACC_WIDTH`, 24, accumulator/result width (must be ≥ `2*DATA_WIDTH+$clog2(COLS)`)
- `ADDR_WIDTH`, 32, word address width
- `SIGNED`, 0, 1 = two's-complement multiply/accumulate, 0 = unsigned

- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — one-cycle request to begin; sampled only in IDLE/DONE
- `base_addr` in `ADDR_WIDTH` — word address of B; A row r at `base_addr+1+r`; sampled with `start`
- `busy` out 1 — high in FILL and CALC
- `done` out 1 — high in DONE, held until next accepted `start`
- `err` out 1 — sticky protocol error, cleared on accepted `start`
- `c_out` out `ROWS*ACC_WIDTH` — result r at `[r*ACC_WIDTH +: ACC_WIDTH]`; valid while `done`
- `mem_address` out `ADDR_WIDTH` — read address
- `mem_read` out 1 — read request
- `mem_readdata` in `COLS*DATA_WIDTH` — read data; lane j at `[j*DATA_WIDTH +: DATA_WIDTH]` = column j
- `mem_readdatavalid` in 1 — response strobe, responses in request order
- `mem_waitrequest` in 1 — request stall

## Operation
- States: IDLE, FILL, CALC, DONE. Reset → IDLE.
- IDLE/DONE + `start`: latch `base_addr`, clear accumulators, `err`, and counters; → FILL. `start` in FILL/CALC ignored.
- FILL: issue `ROWS+1` reads, addresses `base_addr .. base_addr+ROWS`. A request is accepted when `mem_read & ~mem_waitrequest`; the address advances only on acceptance, and `mem_read`/`mem_address` are held stable while stalled. `mem_read` drops the cycle after the last acceptance. Reads are pipelined; there is no limit on outstanding requests.
- Response counter n (0..ROWS): response 0 → B buffer; response n → A row n-1 buffer. After response `ROWS` → CALC.
- CALC: column counter k = 0..COLS-1, one per cycle: `acc[r] += A[r][k]*B[k]` for all r simultaneously. Operands are sign-extended when `SIGNED=1`, otherwise zero-extended, to `ACC_WIDTH`. The sum wraps modulo 2^`ACC_WIDTH`. After k = COLS-1 → DONE.
- DONE: `c_out` = accumulators, held until the next accepted `start`.
- `err` is set by `mem_readdatavalid` in IDLE, CALC or DONE. Such data is discarded, and buffers and state are unaffected.
- `rst` at any time immediately clears state (IDLE), `mem_read`, `busy`, `done`, `err`, `c_out`, counters, and buffers.

## Timing
- Reset values: all outputs 0; `mem_address` = 0.
- `start` at cycle T: FILL and `busy` from T+1, and the first `mem_read` from T+1 with `mem_address=base_addr`.
- With `mem_waitrequest=0`: requests accepted T+1..T+ROWS+1.
- Last response at cycle X: CALC from X+1. Accumulation occurs on the edges ending cycles X+1..X+COLS. DONE and `done=1` from X+COLS+1, with `c_out` final in that same cycle.
- A response and the final acceptance may coincide; both are handled in the same cycle.
- `start` in DONE: `done` drops at T+1, with the same timing as from IDLE.

## Test plan
- Identity: A = I (8x8, diagonal 1), B = 1..8 (lane j = j+1), base 0, no stalls, response latency 2 → `c_out` rows = 1..8; `done` asserted exactly 2+9+8 = 19 cycles after the cycle following `start`. Timing check: last response at T+11, DONE at T+11+8+1 = T+20.
- Signedness: all A = 8'hFF, all B = 8'h02. With `SIGNED=1`, every row = 24'hFFFFF0 (−16). With `SIGNED=0`, every row = 24'h000FF0 (4080).
- Stall: `mem_waitrequest` high for 3 cycles while `mem_address=base_addr+2` → address and `mem_read` held stable, exactly 9 acceptances, results identical to the no-stall run, `done` delayed 3 cycles.
- Handshake: `start` pulsed during FILL and during CALC → ignored (no address restart, results unchanged). Second `start` in DONE with a new `base_addr=16` → fresh results and accumulators not carried over.
- Error: extra `mem_readdatavalid` with data 0xFF.. in DONE → `err=1`, `c_out` unchanged. Next `start` clears `err`.
- Reset mid-CALC: assert `rst` at k=3 → all outputs 0 the same cycle, IDLE. A new `start` after release produces correct results.
